// File: rtl/axi_pkg.sv
// Shared AXI read-channel definitions: burst/response encodings, FSM states,
// AR field widths and the burst address helpers.
package axi_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SIZE_W  = 2;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [BURST_W-1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    // Address of the beat following addr for the given burst shape.
    function automatic logic [ADDR_W-1:0] axi_next_addr(
        input logic [ADDR_W-1:0]  addr,
        input logic [SIZE_W-1:0]  size,
        input logic [LEN_W-1:0]   len,
        input logic [BURST_W-1:0] burst
    );
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << size;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | ((addr + step) & mask);
            default:     return addr + step;
        endcase
    endfunction

    // Request-level errors that poison every beat of the burst.
    function automatic logic axi_cfg_err(
        input logic [SIZE_W-1:0]  size,
        input logic [BURST_W-1:0] burst,
        input logic [LEN_W-1:0]   len
    );
        return (size == 2'b11) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

endpackage

// File: rtl/axi_slave_mem.sv
// Word memory behind the read slave: synchronous preload write, asynchronous read.
module axi_slave_mem #(
    parameter int unsigned DataW = 32,
    parameter int unsigned Words = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(Words)-1:0] waddr,
    input  logic [DataW-1:0]         wdata,
    input  logic [$clog2(Words)-1:0] raddr,
    output logic [DataW-1:0]         rdata
);

    logic [DataW-1:0] mem [Words];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_read_slave.sv
// AXI read responder: one outstanding AR, burst returned in order on R from
// the internal word memory.
module axi_read_slave
    import axi_pkg::*;
#(
    parameter int unsigned BusWidth = 32,
    parameter int unsigned tagbits  = 1,
    parameter int unsigned MemWords = 64
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        mem_we,
    input  logic [$clog2(MemWords)-1:0] mem_waddr,
    input  logic [BusWidth-1:0]         mem_wdata,
    input  logic [tagbits-1:0]          ARID,
    input  logic [BusWidth-1:0]         ARADDR,
    input  logic [LEN_W-1:0]            ARLEN,
    input  logic [SIZE_W-1:0]           ARSIZE,
    input  logic [BURST_W-1:0]          ARBURST,
    input  logic [1:0]                  ARLOCK,
    input  logic [3:0]                  ARCACHE,
    input  logic [2:0]                  ARPROT,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    output logic [tagbits-1:0]          RID,
    output logic [BusWidth-1:0]         RDATA,
    output logic [RESP_W-1:0]           RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY
);

    localparam int unsigned AW = $clog2(MemWords);

    state_e               state;
    logic [BusWidth-1:0]  addr_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [SIZE_W-1:0]    size_q;
    logic [BURST_W-1:0]   burst_q;
    logic                 cfg_err_q;

    logic [BusWidth-1:0]  nxt_addr_c;
    logic [BusWidth-1:0]  rd_addr_c;
    logic [BusWidth-1:0]  rd_data_c;
    logic [AW-1:0]        rd_idx_c;
    logic                 cfg_err_c;
    logic                 rd_err_c;
    logic                 unused_sigs;

    // The beat being loaded is the request start in IDLE, else the next burst address.
    always_comb begin
        nxt_addr_c = axi_next_addr(addr_q, size_q, len_q, burst_q);
        cfg_err_c  = axi_cfg_err(ARSIZE, ARBURST, ARLEN);
        rd_addr_c  = (state == ST_IDLE) ? ARADDR : nxt_addr_c;
        rd_idx_c   = rd_addr_c[AW+1:2];
        rd_err_c   = ((state == ST_IDLE) ? cfg_err_c : cfg_err_q) ||
                     (rd_addr_c[BusWidth-1:AW+2] != '0);
    end

    assign unused_sigs = ^{ARLOCK, ARCACHE, ARPROT, rd_addr_c[1:0]};

    axi_slave_mem #(
        .DataW (BusWidth),
        .Words (MemWords)
    ) u_mem (
        .clk   (ACLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (rd_idx_c),
        .rdata (rd_data_c)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= ST_IDLE;
            ARREADY   <= 1'b0;
            RVALID    <= 1'b0;
            RLAST     <= 1'b0;
            RID       <= '0;
            RDATA     <= '0;
            RRESP     <= RESP_OKAY;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        addr_q    <= ARADDR;
                        len_q     <= ARLEN;
                        cnt_q     <= ARLEN;
                        size_q    <= ARSIZE;
                        burst_q   <= ARBURST;
                        cfg_err_q <= cfg_err_c;
                        RID       <= ARID;
                        RDATA     <= rd_err_c ? '0 : rd_data_c;
                        RRESP     <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
                        RLAST     <= (ARLEN == '0);
                        RVALID    <= 1'b1;
                        ARREADY   <= 1'b0;
                        state     <= ST_BURST;
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (RREADY) begin
                        if (cnt_q == '0) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            ARREADY <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            addr_q <= nxt_addr_c;
                            cnt_q  <= cnt_q - LEN_W'(1);
                            RDATA  <= rd_err_c ? '0 : rd_data_c;
                            RRESP  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
                            RLAST  <= (cnt_q == LEN_W'(1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi_read_slave.md
# axi_read_slave

AXI read-channel responder paired with the team's read master: accepts one AR request at a time, then returns the burst on the R channel from an internal word memory. A testbench-side write port preloads the memory. Sits on the slave side of the AR/R interface, one outstanding transaction, in-order.

## Interface
- BusWidth, 32, data/address width; fixed at 32 for this block.
- tagbits, 1, width of ARID/RID.
- MemWords, 64, memory depth in 32-bit words; power of two.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset; one clock, synchronous, active-high.
- mem_we  in  1  preload write enable.
- mem_waddr  in  log2(MemWords)  preload word index.
- mem_wdata  in  BusWidth  preload data.
- ARID  in  tagbits  transaction ID.
- ARADDR  in  BusWidth  byte start address.
- ARLEN  in  4  beats minus one.
- ARSIZE  in  2  bytes per beat = 1<<ARSIZE; 2'b11 illegal.
- ARBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 illegal.
- ARLOCK/ARCACHE/ARPROT  in  2/4/3  accepted and ignored.
- ARVALID  in  1;  ARREADY  out  1.
- RID  out  tagbits;  RDATA  out  BusWidth;  RRESP  out  2;  RLAST  out  1;  RVALID  out  1.
- RREADY  in  1.

## Operation
- States: IDLE, BURST. Reset → IDLE.
- IDLE: ARREADY=1. On ARVALID&&ARREADY: latch ID, addr, beats=ARLEN+1, size, burst type; load first beat; → BURST; ARREADY=0.
- BURST: RVALID=1. On RVALID&&RREADY: if beat is last → IDLE (ARREADY=1 next cycle); else advance address, load next beat.
- Address advance: FIXED unchanged; INCR addr+(1<<size); WRAP addr+(1<<size) within boundary of total=(ARLEN+1)<<size bytes: next = (addr & ~(total-1)) | ((addr+(1<<size)) & (total-1)).
- RDATA = mem[addr[log2(MemWords)+1:2]], full word, no lane steering.
- RRESP per beat: 00 OKAY; 10 SLVERR if addr ≥ MemWords*4, ARSIZE=11, ARBURST=11, or WRAP with ARLEN not in {1,3,7,15}. On SLVERR, RDATA=0; burst still runs full length with RLAST on final beat.
- RID = latched ARID for every beat. RLAST=1 only on final beat.
- INCR crossing above memory range: beats beyond range individually SLVERR.
- Preload write and R read same word same edge: R beat loaded at that edge carries old data.
- ARVALID while in BURST is ignored (not accepted) until IDLE.

## Timing
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RID=0, RDATA=0, RRESP=0. ARREADY=1 in the first cycle after ARESET deasserts. Memory not reset.
- AR handshake at edge N → RVALID=1 with beat 0 valid after edge N (visible cycle N+1).
- RREADY held high: one beat per cycle; burst of L beats occupies L cycles.
- RVALID&&!RREADY: RID/RDATA/RRESP/RLAST held stable.
- Last-beat handshake at edge M → RVALID=0, ARREADY=1 after M; next AR accepted at M+1 earliest (one idle cycle between bursts).
- ARESET mid-burst: burst abandoned, all outputs to reset values next edge; memory contents retained.
- All R outputs registered; ARREADY registered.

## Structure
- Shared package axi_pkg: burst encodings (FIXED/INCR/WRAP), RRESP encodings (OKAY/EXOKAY/SLVERR/DECERR), state encoding, AR field widths.
- Sub-module axi_slave_mem: MemWords×BusWidth, synchronous write, asynchronous read; top holds FSM, address generator, beat counter.

## Test plan
- Preload mem[0..3]=A0..A3; AR INCR ARADDR=0x0 ARLEN=3 ARSIZE=10 ID=1, RREADY=1 → RDATA A0,A1,A2,A3 on 4 consecutive cycles, RID=1, RRESP=00, RLAST on beat 3, ARREADY=1 one cycle later.
- WRAP ARADDR=0x8 ARLEN=3 ARSIZE=10 → words 2,3,0,1; ARLEN=2 WRAP → 3 beats SLVERR, RDATA=0.
- FIXED ARADDR=0x10 ARLEN=2 → mem[4] three times, RLAST on third.
- INCR ARADDR=0xF8 ARLEN=3 with MemWords=64 → beats 0,1 OKAY (words 62,63), beats 2,3 SLVERR.
- RREADY toggled 1,0,0,1… during 4-beat INCR → outputs stable while stalled; exact 4 handshakes; second ARVALID asserted mid-burst not accepted until IDLE.
- ARESET pulsed during beat 1 → all outputs reset next edge, ARREADY=1 the cycle after release, fresh request completes correctly with preloaded data intact.
